legv8_multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the LEGv8 datapath.
- Latches the 32-bit instruction from the instruction ROM, decodes it, and drives the 30-bit datapath control word plus the 64-bit constant, one state per cycle.
- Guarantees at most one driver on the shared 64-bit data bus per cycle.
- Sits between the instruction ROM and the datapath; consumes datapath status for conditional branches.

---
 rtl/legv8_ctrl_pkg.sv | 62 ++++++
 rtl/legv8_decode.sv | 48 ++++
 rtl/legv8_multicycle_sequencer.sv | 169 ++++++++++++++++
 tb/tb_legv8_multicycle_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control path: FSM states, PS/FS codes,
// opcode match values and control-word field positions.
package legv8_ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_BRANCH = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd7;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_ABUS = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // Control word, MSB first: {EN_PC,EN_Mem,EN_ALU,PCsel,Bsel,SL,WM,WR,PS,FS,SB,SA,DA}
  localparam int unsigned CW_EN_PC  = 29;
  localparam int unsigned CW_EN_MEM = 28;
  localparam int unsigned CW_EN_ALU = 27;
  localparam int unsigned CW_PCSEL  = 26;
  localparam int unsigned CW_BSEL   = 25;
  localparam int unsigned CW_SL     = 24;
  localparam int unsigned CW_WM     = 23;
  localparam int unsigned CW_WR     = 22;
  localparam int unsigned CW_PS     = 20;
  localparam int unsigned CW_FS     = 15;
  localparam int unsigned CW_SB     = 10;
  localparam int unsigned CW_SA     = 5;
  localparam int unsigned CW_DA     = 0;

  typedef enum logic [3:0] {
    CLS_UNDEF, CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR, CLS_ADDI,
    CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_BR
  } op_class_e;

  function automatic logic [4:0] alu_fs(input op_class_e cls);
    case (cls)
      CLS_SUB: return FS_SUB;
      CLS_AND: return FS_AND;
      CLS_ORR: return FS_ORR;
      default: return FS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/legv8_decode.sv
// Combinational instruction decode: opcode class, register fields and the
// sign/zero-extended constants the FSM puts on the constant output.
module legv8_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int IMM_W = 64  // must be at least 28 to hold the B offset
) (
  input  logic [31:0]      ir,
  output op_class_e        op_class,
  output logic [4:0]       rd,
  output logic [4:0]       rn,
  output logic [4:0]       rm,
  output logic [IMM_W-1:0] exec_const,
  output logic [IMM_W-1:0] cbz_const
);

  assign rd = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];

  always_comb begin
    op_class = CLS_UNDEF;
    if      (ir[31:21] == OP_ADD)  op_class = CLS_ADD;
    else if (ir[31:21] == OP_SUB)  op_class = CLS_SUB;
    else if (ir[31:21] == OP_AND)  op_class = CLS_AND;
    else if (ir[31:21] == OP_ORR)  op_class = CLS_ORR;
    else if (ir[31:21] == OP_LDUR) op_class = CLS_LDUR;
    else if (ir[31:21] == OP_STUR) op_class = CLS_STUR;
    else if (ir[31:21] == OP_BR)   op_class = CLS_BR;
    else if (ir[31:22] == OP_ADDI) op_class = CLS_ADDI;
    else if (ir[31:24] == OP_CBZ)  op_class = CLS_CBZ;
    else if (ir[31:26] == OP_B)    op_class = CLS_B;
  end

  // Branch offsets subtract 4 because the PC was already advanced in FETCH.
  always_comb begin
    exec_const = '0;
    case (op_class)
      CLS_ADDI:           exec_const = {{(IMM_W-12){1'b0}}, ir[21:10]};
      CLS_LDUR, CLS_STUR: exec_const = {{(IMM_W-9){ir[20]}}, ir[20:12]};
      CLS_B:              exec_const = {{(IMM_W-28){ir[25]}}, ir[25:0], 2'b00} - IMM_W'(4);
      default:            exec_const = '0;
    endcase
  end

  assign cbz_const = {{(IMM_W-21){ir[23]}}, ir[23:5], 2'b00} - IMM_W'(4);

endmodule

// File: rtl/legv8_multicycle_sequencer.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/BRANCH/HALT, one control word per cycle.
// Optional LEGV8_PERF_COUNT_EN adds cycle_count and retired_count outputs.
module legv8_multicycle_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int IMM_W         = 64,
  parameter bit HALT_ON_UNDEF = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [4:0]       status,
  output logic [29:0]      control_word,
  output logic [IMM_W-1:0] constant,
  output logic [2:0]       state,
  output logic             halted
`ifdef LEGV8_PERF_COUNT_EN
  ,
  output logic [31:0]      cycle_count,
  output logic [31:0]      retired_count
`endif
);

  logic [2:0]       state_q, state_d;
  logic [31:0]      ir_q;
  logic             taken_q;
  op_class_e        cls;
  logic [4:0]       rd, rn, rm;
  logic [IMM_W-1:0] exec_const, cbz_const;
  logic [29:0]      cw;
  logic [IMM_W-1:0] k;
  logic             unused_status;

  assign unused_status = ^status[4:1];

  legv8_decode #(.IMM_W(IMM_W)) u_decode (
    .ir         (ir_q),
    .op_class   (cls),
    .rd         (rd),
    .rn         (rn),
    .rm         (rm),
    .exec_const (exec_const),
    .cbz_const  (cbz_const)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) ir_q <= instruction;
      if (state_q == ST_EXEC && cls == CLS_CBZ) taken_q <= status[0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (cls == CLS_UNDEF) state_d = HALT_ON_UNDEF ? ST_HALT : ST_FETCH;
        else                  state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_LDUR, CLS_STUR: state_d = ST_MEM;
          CLS_CBZ:            state_d = status[0] ? ST_BRANCH : ST_FETCH;
          default:            state_d = ST_FETCH;
        endcase
      end
      ST_MEM, ST_BRANCH: state_d = ST_FETCH;
      ST_HALT:           state_d = ST_HALT;
      default:           state_d = ST_FETCH;
    endcase
  end

  // Only EN_ALU (EXEC) or EN_Mem (MEM) ever drives the shared bus, never in the same state.
  always_comb begin
    cw = '0;
    k  = '0;
    case (state_q)
      ST_FETCH: cw[CW_PS +: 2] = PS_INC;
      ST_EXEC: begin
        case (cls)
          CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR: begin
            cw[CW_SA +: 5] = rn;
            cw[CW_SB +: 5] = rm;
            cw[CW_DA +: 5] = rd;
            cw[CW_FS +: 5] = alu_fs(cls);
            cw[CW_SL]      = (cls == CLS_SUB);
            cw[CW_EN_ALU]  = 1'b1;
            cw[CW_WR]      = 1'b1;
          end
          CLS_ADDI: begin
            cw[CW_SA +: 5] = rn;
            cw[CW_DA +: 5] = rd;
            cw[CW_FS +: 5] = FS_ADD;
            cw[CW_BSEL]    = 1'b1;
            cw[CW_EN_ALU]  = 1'b1;
            cw[CW_WR]      = 1'b1;
            k              = exec_const;
          end
          CLS_LDUR, CLS_STUR: begin
            cw[CW_SA +: 5] = rn;
            cw[CW_FS +: 5] = FS_ADD;
            cw[CW_BSEL]    = 1'b1;
            k              = exec_const;
          end
          CLS_CBZ: begin
            cw[CW_SA +: 5] = rd;
            cw[CW_FS +: 5] = FS_ADD;
            cw[CW_BSEL]    = 1'b1;
          end
          CLS_B: begin
            cw[CW_PS +: 2] = PS_REL;
            k              = exec_const;
          end
          CLS_BR: begin
            cw[CW_SA +: 5] = rn;
            cw[CW_PS +: 2] = PS_ABUS;
          end
          default: cw = '0;
        endcase
      end
      ST_MEM: begin
        cw[CW_SA +: 5] = rn;
        cw[CW_FS +: 5] = FS_ADD;
        cw[CW_BSEL]    = 1'b1;
        k              = exec_const;
        if (cls == CLS_LDUR) begin
          cw[CW_EN_MEM]  = 1'b1;
          cw[CW_WR]      = 1'b1;
          cw[CW_DA +: 5] = rd;
        end else if (cls == CLS_STUR) begin
          cw[CW_SB +: 5] = rd;
          cw[CW_WM]      = 1'b1;
        end
      end
      ST_BRANCH: begin
        if (taken_q) cw[CW_PS +: 2] = PS_REL;
        k = cbz_const;
      end
      default: cw = '0;
    endcase
  end

  // Reset masks the outputs combinationally so no write strobe survives an abort.
  assign control_word = reset ? cw : '0;
  assign constant     = reset ? k : '0;
  assign state        = state_q;
  assign halted       = reset & (state_q == ST_HALT);

`ifdef LEGV8_PERF_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (state_q != ST_HALT) cycle_count <= cycle_count + 32'd1;
      if (state_d == ST_FETCH &&
          (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_BRANCH))
        retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_legv8_multicycle_sequencer.sv
// Directed bench for legv8_multicycle_sequencer: per-state control words, latencies,
// halt/reset behaviour and a random stream with bus/write exclusivity checks.
module tb_legv8_multicycle_sequencer;

  localparam int IMM_W = 64;

  logic             clock;
  logic             reset;
  logic [31:0]      instruction;
  logic [4:0]       status;
  logic [29:0]      control_word;
  logic [IMM_W-1:0] constant;
  logic [2:0]       state;
  logic             halted;
`ifdef LEGV8_PERF_COUNT_EN
  logic [31:0]      cycle_count;
  logic [31:0]      retired_count;
`endif

  int checks = 0;
  int errors = 0;

  legv8_multicycle_sequencer #(.IMM_W(IMM_W), .HALT_ON_UNDEF(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .constant     (constant),
    .state        (state),
    .halted       (halted)
`ifdef LEGV8_PERF_COUNT_EN
    ,
    .cycle_count  (cycle_count),
    .retired_count(retired_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // en = {EN_PC,EN_Mem,EN_ALU}; fl = {PCsel,Bsel,SL,WM,WR}
  function automatic logic [29:0] mk_cw(input logic [2:0] en, input logic [4:0] fl,
                                        input logic [1:0] ps, input logic [4:0] fs,
                                        input logic [4:0] sb, input logic [4:0] sa,
                                        input logic [4:0] da);
    return {en, fl, ps, fs, sb, sa, da};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [2:0] st,
                              input logic [29:0] cw, input logic [IMM_W-1:0] k);
    @(negedge clock);
    chk({tag, ".state"}, 64'(state), 64'(st));
    chk({tag, ".cw"}, 64'(control_word), 64'(cw));
    chk({tag, ".const"}, constant, k);
  endtask

  // Bus-driver and write-strobe exclusivity, every cycle out of reset.
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      assert ((32'(control_word[29]) + 32'(control_word[28]) + 32'(control_word[27])) <= 1)
      else begin
        errors++;
        $error("FAIL bus_drivers: observed en=%b expected at most one", control_word[29:27]);
      end
      checks++;
      assert (!(control_word[22] && control_word[23])) else begin
        errors++;
        $error("FAIL wr_wm_excl: observed WR=%b WM=%b expected not both",
               control_word[22], control_word[23]);
      end
    end
  end

  logic [29:0] cw_fetch;
  logic [29:0] cw_zero;

  initial begin
    logic [31:0] r;
    int          kind, lat, cyc;

    cw_fetch = mk_cw(3'b000, 5'b00000, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0);
    cw_zero  = '0;
    reset = 1'b0;
    instruction = 32'h0;
    status = 5'b0;

    // Reset held for two cycles
    repeat (2) @(negedge clock);
    chk("reset.state", 64'(state), 64'd0);
    chk("reset.cw", 64'(control_word), 64'd0);
    chk("reset.const", constant, 64'd0);
    chk("reset.halted", 64'(halted), 64'd0);
    reset = 1'b1;
    #1;
    chk("release.state", 64'(state), 64'd0);
    chk("release.cw", 64'(control_word), 64'(cw_fetch));

    // ADD X3,X1,X2
    instruction = 32'h8B020023;
    expect_cycle("add.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("add.exec", 3'd2, mk_cw(3'b001, 5'b00001, 2'b00, 5'b01000, 5'd2, 5'd1, 5'd3), 64'd0);
    expect_cycle("add.fetch", 3'd0, cw_fetch, 64'd0);

    // SUB X1,X2,X3
    instruction = {11'b11001011000, 5'd3, 6'd0, 5'd2, 5'd1};
    expect_cycle("sub.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("sub.exec", 3'd2, mk_cw(3'b001, 5'b00101, 2'b00, 5'b01001, 5'd3, 5'd2, 5'd1), 64'd0);
    expect_cycle("sub.fetch", 3'd0, cw_fetch, 64'd0);

    // ORR X4,X5,X6
    instruction = {11'b10101010000, 5'd6, 6'd0, 5'd5, 5'd4};
    expect_cycle("orr.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("orr.exec", 3'd2, mk_cw(3'b001, 5'b00001, 2'b00, 5'b00100, 5'd6, 5'd5, 5'd4), 64'd0);
    expect_cycle("orr.fetch", 3'd0, cw_fetch, 64'd0);

    // ADDI X9,X10,#4095 (zero-extended)
    instruction = {10'b1001000100, 12'hFFF, 5'd10, 5'd9};
    expect_cycle("addi.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("addi.exec", 3'd2, mk_cw(3'b001, 5'b01001, 2'b00, 5'b01000, 5'd0, 5'd10, 5'd9), 64'd4095);
    expect_cycle("addi.fetch", 3'd0, cw_fetch, 64'd0);

    // LDUR X5,[X4,#8]
    instruction = 32'hF8408085;
    expect_cycle("ldur.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("ldur.exec", 3'd2, mk_cw(3'b000, 5'b01000, 2'b00, 5'b01000, 5'd0, 5'd4, 5'd0), 64'd8);
    expect_cycle("ldur.mem", 3'd3, mk_cw(3'b010, 5'b01001, 2'b00, 5'b01000, 5'd0, 5'd4, 5'd5), 64'd8);
    expect_cycle("ldur.fetch", 3'd0, cw_fetch, 64'd0);

    // STUR X6,[X2,#-8]
    instruction = {11'b11111000000, 9'h1F8, 2'b00, 5'd2, 5'd6};
    expect_cycle("stur.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("stur.exec", 3'd2, mk_cw(3'b000, 5'b01000, 2'b00, 5'b01000, 5'd0, 5'd2, 5'd0),
                 64'hFFFF_FFFF_FFFF_FFF8);
    expect_cycle("stur.mem", 3'd3, mk_cw(3'b000, 5'b01010, 2'b00, 5'b01000, 5'd6, 5'd2, 5'd0),
                 64'hFFFF_FFFF_FFFF_FFF8);
    expect_cycle("stur.fetch", 3'd0, cw_fetch, 64'd0);

    // CBZ X7,+16 taken
    instruction = 32'hB4000087;
    status = 5'b11111;
    expect_cycle("cbz_t.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("cbz_t.exec", 3'd2, mk_cw(3'b000, 5'b01000, 2'b00, 5'b01000, 5'd0, 5'd7, 5'd0), 64'd0);
    expect_cycle("cbz_t.branch", 3'd4, mk_cw(3'b000, 5'b00000, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'd12);
    expect_cycle("cbz_t.fetch", 3'd0, cw_fetch, 64'd0);

    // CBZ X7,+16 not taken (other status bits set must not matter)
    status = 5'b11110;
    expect_cycle("cbz_n.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("cbz_n.exec", 3'd2, mk_cw(3'b000, 5'b01000, 2'b00, 5'b01000, 5'd0, 5'd7, 5'd0), 64'd0);
    expect_cycle("cbz_n.fetch", 3'd0, cw_fetch, 64'd0);
    status = 5'b0;

    // B -4 : constant = -4 - 4 = -8
    instruction = {6'b000101, 26'h3FF_FFFF};
    expect_cycle("b.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("b.exec", 3'd2, mk_cw(3'b000, 5'b00000, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0),
                 64'hFFFF_FFFF_FFFF_FFF8);
    expect_cycle("b.fetch", 3'd0, cw_fetch, 64'd0);

    // B +8 : constant = 8 - 4 = 4
    instruction = {6'b000101, 26'd2};
    expect_cycle("bf.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("bf.exec", 3'd2, mk_cw(3'b000, 5'b00000, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'd4);
    expect_cycle("bf.fetch", 3'd0, cw_fetch, 64'd0);

    // BR X30
    instruction = {11'b11010110000, 5'b11111, 6'd0, 5'd30, 5'd0};
    expect_cycle("br.decode", 3'd1, cw_zero, 64'd0);
    expect_cycle("br.exec", 3'd2, mk_cw(3'b000, 5'b00000, 2'b10, 5'd0, 5'd0, 5'd30, 5'd0), 64'd0);
    expect_cycle("br.fetch", 3'd0, cw_fetch, 64'd0);

    // Undefined word halts and stays halted
    instruction = 32'h0000_0000;
    expect_cycle("undef.decode", 3'd1, cw_zero, 64'd0);
    chk("undef.decode_halted", 64'(halted), 64'd0);
    for (int i = 0; i < 10; i++) begin
      expect_cycle("halt", 3'd7, cw_zero, 64'd0);
      chk("halt.halted", 64'(halted), 64'd1);
    end

    // Reset pulse mid-halt
    reset = 1'b0;
    #1;
    chk("halt_rst.state", 64'(state), 64'd0);
    chk("halt_rst.halted", 64'(halted), 64'd0);
    chk("halt_rst.cw", 64'(control_word), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("halt_rel.state", 64'(state), 64'd0);
    chk("halt_rel.cw", 64'(control_word), 64'(cw_fetch));

    // Random valid instruction stream with latency check per instruction
    for (int n = 0; n < 1000; n++) begin
      r = $urandom;
      kind = $urandom_range(0, 9);
      status = 5'($urandom_range(0, 31));
      case (kind)
        0: instruction = {11'b10001011000, r[20:0]};
        1: instruction = {11'b11001011000, r[20:0]};
        2: instruction = {11'b10001010000, r[20:0]};
        3: instruction = {11'b10101010000, r[20:0]};
        4: instruction = {10'b1001000100, r[21:0]};
        5: instruction = {11'b11111000010, r[20:0]};
        6: instruction = {11'b11111000000, r[20:0]};
        7: instruction = {8'b10110100, r[23:0]};
        8: instruction = {6'b000101, r[25:0]};
        default: instruction = {11'b11010110000, r[20:0]};
      endcase
      lat = (kind == 5 || kind == 6 || (kind == 7 && status[0])) ? 4 : 3;
      cyc = 0;
      do begin
        @(negedge clock);
        cyc++;
      end while (state !== 3'd0 && cyc < 8);
      chk("stream.latency", 64'(cyc), 64'(lat));
    end

`ifdef LEGV8_PERF_COUNT_EN
    chk("stream.retired", 64'(retired_count), 64'd1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
